// File: rtl/imem_responder.sv
// imem_responder: word-addressed instruction store with fixed-latency read pipeline, FWFT response buffer and credit-limited request acceptance
module imem_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_3000,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 1,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          flush,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);
  localparam int CAP = LATENCY + 1;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [64:0] r_pipe [LATENCY];
  logic [LATENCY-1:0] r_pv;
  logic [64:0] r_fifo [CAP];
  logic [2:0] r_occ, r_count;
  logic [29:0] w_idx;
  logic w_fault, w_acc, w_pop, w_popf, w_push, w_fempty;
  logic [2:0] w_wr;
  logic [64:0] w_in, w_head;
  assign w_idx = 30'((req_addr - ADDR_BASE) >> 2);
  assign w_fault = |req_addr[1:0] || req_addr < ADDR_BASE || w_idx >= 30'(DEPTH_WORDS);
  assign w_in = {req_addr, w_fault, w_fault ? 32'h0 : r_mem[w_idx[AW-1:0]]};
  assign req_ready = !rst && !flush && r_count < 3'(CAP);
  assign w_acc = req_valid && req_ready;
  assign w_fempty = r_occ == 3'd0;
  assign w_head = w_fempty ? r_pipe[LATENCY-1] : r_fifo[0];
  assign rsp_valid = !w_fempty || r_pv[LATENCY-1];
  assign {rsp_addr, rsp_err, rsp_instr} = w_head;
  assign w_pop = rsp_valid && rsp_ready;
  assign w_popf = w_pop && !w_fempty;
  assign w_push = r_pv[LATENCY-1] && !(w_fempty && w_pop);
  assign w_wr = r_occ - 3'(w_popf);
  always_ff @(posedge clk)
    if (ld_we) r_mem[ld_addr] <= ld_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pv[0] <= w_acc;
      r_pipe[0] <= w_acc ? w_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1] && !flush;
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) r_occ <= '0;
    else begin
      for (int i = 0; i < CAP - 1; i++)
        if (w_popf) r_fifo[i] <= r_fifo[i+1];
      for (int i = 0; i < CAP; i++)
        if (w_push && 3'(i) == w_wr) r_fifo[i] <= r_pipe[LATENCY-1];
      r_occ <= r_occ + 3'(w_push) - 3'(w_popf);
    end
  end
  always_ff @(posedge clk)
    r_count <= (rst || flush) ? '0 : r_count + 3'(w_acc) - 3'(w_pop);
endmodule
